// File: rtl/spi_flash_slave_model_if.sv
// SPI pin bundle plus the model's status mirrors and command-monitor outputs.
interface spi_flash_slave_model_if;
  logic       spi_clk;
  logic       spi_cs_n;
  logic       spi_mosi;
  logic       spi_miso;
  logic       busy;
  logic       wel;
  logic       cmd_strobe;
  logic [7:0] cmd_byte;
  logic       bad_cmd;

  modport master (
    output spi_clk, spi_cs_n, spi_mosi,
    input  spi_miso, busy, wel, cmd_strobe, cmd_byte, bad_cmd
  );

  modport slave (
    input  spi_clk, spi_cs_n, spi_mosi,
    output spi_miso, busy, wel, cmd_strobe, cmd_byte, bad_cmd
  );
endinterface

// File: rtl/spi_flash_slave_model.sv
// SPI serial-flash slave model: oversamples the SPI pins in the CLKA domain and decodes
// READ, PAGE PROGRAM, WREN, WRDI, RDSR and JEDEC ID against a small backing store.
module spi_flash_slave_model #(
  parameter int          ADDR_BYTES  = 3,
  parameter int          MEM_DEPTH   = 256,
  parameter int          PAGE_SIZE   = 256,
  parameter logic [23:0] JEDEC_ID    = 24'hEF4018,
  parameter int          PROG_CYCLES = 1000,
  parameter logic [7:0]  FILL_BYTE   = 8'hFF
) (
  input logic                     CLKA,
  input logic                     rst,
  spi_flash_slave_model_if.slave  bus
);
  localparam int AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam int CW = (PROG_CYCLES > 0) ? $clog2(PROG_CYCLES + 1) : 1;
  localparam logic [AW-1:0] PAGE_MASK = AW'(PAGE_SIZE - 1);
  localparam logic [AW-1:0] LAST_ADDR = AW'(MEM_DEPTH - 1);
  localparam logic [1:0]    LAST_AB   = 2'(ADDR_BYTES - 1);

  typedef enum logic [2:0] {
    IDLE, CMD, ADDR, RD_DATA, WR_DATA, STATUS, ID, IGNORE
  } state_t;

  state_t         state;
  logic [2:0]     bit_cnt;
  logic [1:0]     ab_cnt;
  logic [1:0]     id_idx;
  logic           is_prog;
  logic           wr_any;
  logic           busy_r;
  logic [CW-1:0]  busy_cnt;
  logic           wel_r;
  logic           strobe_r;
  logic [7:0]     cmd_r;
  logic           bad_r;
  logic           miso_r;

  logic [6:0]     rx_sh;
  logic [7:0]     tx_sh;
  logic [23:0]    acc;
  logic [AW-1:0]  addr;
  logic [7:0]     tx_load;
  logic [7:0]     rd_byte;

  logic [7:0] mem [MEM_DEPTH] = '{default: FILL_BYTE};

  // Stage p0..p2: pin synchronisers; p2 exists only for edge detection
  logic clk_p0, clk_p1, clk_p2;
  logic cs_p0, cs_p1, cs_p2;
  logic mosi_p0, mosi_p1;

  always_ff @(posedge CLKA or posedge rst) begin
    if (rst) begin
      clk_p0  <= 1'b0;
      clk_p1  <= 1'b0;
      clk_p2  <= 1'b0;
      cs_p0   <= 1'b1;
      cs_p1   <= 1'b1;
      cs_p2   <= 1'b1;
      mosi_p0 <= 1'b0;
      mosi_p1 <= 1'b0;
    end else begin
      clk_p0  <= bus.spi_clk;
      clk_p1  <= clk_p0;
      clk_p2  <= clk_p1;
      cs_p0   <= bus.spi_cs_n;
      cs_p1   <= cs_p0;
      cs_p2   <= cs_p1;
      mosi_p0 <= bus.spi_mosi;
      mosi_p1 <= mosi_p0;
    end
  end

  logic sclk_rise, sclk_fall, cs_fall, cs_rise, active, bit_in, fall_act, byte_done, tx_state;
  logic [7:0] byte_in;

  assign sclk_rise = clk_p1 & ~clk_p2;
  assign sclk_fall = ~clk_p1 & clk_p2;
  assign cs_fall   = ~cs_p1 & cs_p2;
  assign cs_rise   = cs_p1 & ~cs_p2;
  assign active    = (state != IDLE) && !cs_p1;
  assign bit_in    = active && sclk_rise;
  assign fall_act  = active && sclk_fall;
  assign byte_done = bit_in && (bit_cnt == 3'd7);
  assign byte_in   = {rx_sh, mosi_p1};
  assign tx_state  = (state == RD_DATA) || (state == STATUS) || (state == ID);
  assign rd_byte   = mem[addr];

  always_comb begin
    tx_load = 8'h00;
    case (state)
      RD_DATA: tx_load = rd_byte;
      STATUS:  tx_load = {6'b0, wel_r, busy_r};
      ID: begin
        case (id_idx)
          2'd0:    tx_load = JEDEC_ID[23:16];
          2'd1:    tx_load = JEDEC_ID[15:8];
          2'd2:    tx_load = JEDEC_ID[7:0];
          default: tx_load = 8'h00;
        endcase
      end
      default: tx_load = 8'h00;
    endcase
  end

  // Stage p3: command FSM, status bits and MISO driver
  always_ff @(posedge CLKA or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      bit_cnt  <= 3'd0;
      ab_cnt   <= 2'd0;
      id_idx   <= 2'd0;
      is_prog  <= 1'b0;
      wr_any   <= 1'b0;
      busy_r   <= 1'b0;
      busy_cnt <= '0;
      wel_r    <= 1'b0;
      strobe_r <= 1'b0;
      cmd_r    <= 8'h00;
      bad_r    <= 1'b0;
      miso_r   <= 1'b0;
    end else begin
      strobe_r <= 1'b0;
      if (busy_r) begin
        if (busy_cnt == '0) busy_r <= 1'b0;
        else                busy_cnt <= busy_cnt - CW'(1);
      end

      if (cs_rise) begin
        state   <= IDLE;
        bit_cnt <= 3'd0;
        miso_r  <= 1'b0;
        // Only a program that committed at least one byte starts the write cycle
        if (state == WR_DATA && wr_any) begin
          busy_r   <= 1'b1;
          wel_r    <= 1'b0;
          busy_cnt <= CW'(PROG_CYCLES);
        end
      end else if (state == IDLE) begin
        if (cs_fall) begin
          state   <= CMD;
          bit_cnt <= 3'd0;
        end
      end else begin
        if (bit_in) bit_cnt <= bit_cnt + 3'd1;
        if (byte_done) begin
          case (state)
            CMD: begin
              strobe_r <= 1'b1;
              cmd_r    <= byte_in;
              ab_cnt   <= 2'd0;
              id_idx   <= 2'd0;
              wr_any   <= 1'b0;
              if (busy_r && byte_in != 8'h05) begin
                state <= IGNORE;
                bad_r <= 1'b1;
              end else begin
                case (byte_in)
                  8'h03: begin state <= ADDR; is_prog <= 1'b0; end
                  8'h02: begin
                    if (wel_r) begin state <= ADDR; is_prog <= 1'b1; end
                    else state <= IGNORE;
                  end
                  8'h06: begin wel_r <= 1'b1; state <= IGNORE; end
                  8'h04: begin wel_r <= 1'b0; state <= IGNORE; end
                  8'h05: state <= STATUS;
                  8'h9F: state <= ID;
                  default: begin state <= IGNORE; bad_r <= 1'b1; end
                endcase
              end
            end
            ADDR: begin
              if (ab_cnt == LAST_AB) state <= is_prog ? WR_DATA : RD_DATA;
              else                   ab_cnt <= ab_cnt + 2'd1;
            end
            WR_DATA: wr_any <= 1'b1;
            default: ;
          endcase
        end
        if (fall_act) begin
          if (!tx_state) begin
            miso_r <= 1'b0;
          end else if (bit_cnt == 3'd0) begin
            miso_r <= tx_load[7];
            if (state == ID && id_idx != 2'd3) id_idx <= id_idx + 2'd1;
          end else begin
            miso_r <= tx_sh[7];
          end
        end
      end
    end
  end

  // Stage p3 data side: shift registers, address pointer and array write port
  always_ff @(posedge CLKA) begin
    if (bit_in) rx_sh <= byte_in[6:0];
    if (byte_done) begin
      case (state)
        CMD: acc <= '0;
        ADDR: begin
          acc <= {acc[15:0], byte_in};
          if (ab_cnt == LAST_AB) addr <= AW'({acc, byte_in} % 32'(MEM_DEPTH));
        end
        WR_DATA: begin
          mem[addr] <= byte_in;
          addr      <= (addr & ~PAGE_MASK) | ((addr + AW'(1)) & PAGE_MASK);
        end
        default: ;
      endcase
    end
    if (fall_act) begin
      if (bit_cnt == 3'd0) begin
        tx_sh <= {tx_load[6:0], 1'b0};
        if (state == RD_DATA) addr <= (addr == LAST_ADDR) ? '0 : addr + AW'(1);
      end else begin
        tx_sh <= {tx_sh[6:0], 1'b0};
      end
    end
  end

  assign bus.spi_miso   = miso_r;
  assign bus.busy       = busy_r;
  assign bus.wel        = wel_r;
  assign bus.cmd_strobe = strobe_r;
  assign bus.cmd_byte   = cmd_r;
  assign bus.bad_cmd    = bad_r;
endmodule
